// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and
// the sizing rule for the bit counter.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter width: enough bits to reach WIDTH-1, but never zero bits.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: x - y - bin, giving difference d and borrow bout.
// Mirror image of the full adder cell; also meant for a ripple subtractor.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference is the three-way parity; a borrow is produced when the
    // minuend bit is smaller than subtrahend plus incoming borrow.
    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - borrow_in LSB first, one bit per
// clock, with valid/ready handshakes on the operand and result sides.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero
);

    localparam int             CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;
    logic             zero_q, zero_d;

    logic             cell_d;
    logic             cell_bout;
    logic [WIDTH-1:0] diff_shift;

    full_subtractor u_cell (
        .x    (a_sh_q[0]),
        .y    (b_sh_q[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // New difference bit enters at the MSB; after WIDTH shifts bit 0 of the
    // result has travelled down to diff[0].
    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign diff_shift = cell_d;
        end else begin : g_shift_wn
            assign diff_shift = {cell_d, diff_q[WIDTH-1:1]};
        end
    endgenerate

    // Next-state logic for the whole datapath and the IDLE/RUN/DONE FSM.
    always_comb begin
        state_d      = state_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        borrow_d     = borrow_q;
        cnt_d        = cnt_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        zero_d       = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    borrow_d = borrow_in;
                    diff_d   = '0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                borrow_d = cell_bout;
                diff_d   = diff_shift;
                if (cnt_q == CNT_LAST) begin
                    // Last bit: latch the final borrow and zero flag together
                    // with the completed difference; counter stays at WIDTH-1.
                    borrow_out_d = cell_bout;
                    zero_d       = (diff_shift == '0);
                    state_d      = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            borrow_q     <= 1'b0;
            cnt_q        <= '0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            zero_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            borrow_q     <= borrow_d;
            cnt_q        <= cnt_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            zero_q       <= zero_d;
        end
    end

    // Handshake flags decode straight from the registered state.
    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
    assign zero       = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed 8-bit vector table,
// reset/handshake sequences, and exhaustive sweeps at WIDTH=4 and WIDTH=1.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n;

    // WIDTH=8 instance
    logic       iv8, ir8, bi8, ov8, or8, bo8, z8;
    logic [7:0] a8, b8, d8;
    // WIDTH=4 instance
    logic       iv4, ir4, bi4, ov4, or4, bo4, z4;
    logic [3:0] a4, b4, d4;
    // WIDTH=1 instance
    logic       iv1, ir1, bi1, ov1, or1, bo1, z1;
    logic [0:0] a1, b1, d1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .borrow_in(bi8), .out_valid(ov8), .out_ready(or8),
        .diff(d8), .borrow_out(bo8), .zero(z8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .borrow_in(bi4), .out_valid(ov4), .out_ready(or4),
        .diff(d4), .borrow_out(bo4), .zero(z4)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .borrow_in(bi1), .out_valid(ov1), .out_ready(or1),
        .diff(d1), .borrow_out(bo1), .zero(z1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] exp_diff;
        logic       exp_borrow;
        logic       exp_zero;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Full 8-bit transaction; operands are scrambled every cycle after the
    // accept edge, so the result must come from the captured values.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                       input logic [7:0] ed, input logic eb, input logic ez, input string tag);
        int w;
        int lat;
        w = 0;
        while (ir8 !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        check({tag, "_in_ready"}, 32'(ir8), 32'd1);
        iv8 = 1'b1; a8 = av; b8 = bv; bi8 = bi;
        @(negedge clk);
        iv8 = 1'b0;
        check({tag, "_busy"}, 32'(ir8), 32'd0);
        lat = 0;
        while (ov8 !== 1'b1 && lat < 50) begin
            a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd8);
        check({tag, "_diff"}, 32'(d8), 32'(ed));
        check({tag, "_borrow"}, 32'(bo8), 32'(eb));
        check({tag, "_zero"}, 32'(z8), 32'(ez));
        $display("op8 %s: a=%02h b=%02h bin=%0d -> diff=%02h borrow=%0d zero=%0d lat=%0d",
                 tag, av, bv, bi, d8, bo8, z8, lat);
        or8 = 1'b1;
        @(negedge clk);
        or8 = 1'b0;
        check({tag, "_released"}, 32'(ov8), 32'd0);
    endtask

    task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic bi);
        logic [4:0] ref5;
        int lat;
        ref5 = {1'b0, av} - {1'b0, bv} - {4'b0, bi};
        iv4 = 1'b1; a4 = av; b4 = bv; bi4 = bi;
        @(negedge clk);
        iv4 = 1'b0;
        lat = 0;
        while (ov4 !== 1'b1 && lat < 30) begin
            a4 = 4'($urandom); b4 = 4'($urandom); bi4 = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        check("w4_latency", 32'(lat), 32'd4);
        check("w4_diff", 32'(d4), 32'(ref5[3:0]));
        check("w4_borrow", 32'(bo4), 32'(ref5[4]));
        check("w4_zero", 32'(z4), 32'(ref5[3:0] == 4'd0));
        or4 = 1'b1;
        @(negedge clk);
        or4 = 1'b0;
    endtask

    task automatic op1(input logic av, input logic bv, input logic bi);
        logic [1:0] ref2;
        int lat;
        ref2 = {1'b0, av} - {1'b0, bv} - {1'b0, bi};
        iv1 = 1'b1; a1 = av; b1 = bv; bi1 = bi;
        @(negedge clk);
        iv1 = 1'b0;
        lat = 0;
        while (ov1 !== 1'b1 && lat < 30) begin @(negedge clk); lat++; end
        check("w1_latency", 32'(lat), 32'd1);
        check("w1_diff", 32'(d1), 32'(ref2[0]));
        check("w1_borrow", 32'(bo1), 32'(ref2[1]));
        check("w1_zero", 32'(z1), 32'(ref2[0] == 1'b0));
        $display("op1: a=%0d b=%0d bin=%0d -> diff=%0d borrow=%0d zero=%0d", av, bv, bi, d1, bo1, z1);
        or1 = 1'b1;
        @(negedge clk);
        or1 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[10];
        int lat;
        vecs[0] = '{8'd100, 8'd58, 1'b0, 8'd42, 1'b0, 1'b0};
        vecs[1] = '{8'd3,   8'd5,  1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'd0,   8'd0,  1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'hA5,  8'hA5, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[4] = '{8'h80,  8'h7F, 1'b1, 8'h00, 1'b0, 1'b1};
        vecs[5] = '{8'hFF,  8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[6] = '{8'h00,  8'hFF, 1'b0, 8'h01, 1'b1, 1'b0};
        vecs[7] = '{8'hFF,  8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[8] = '{8'h55,  8'hAA, 1'b0, 8'hAB, 1'b1, 1'b0};
        vecs[9] = '{8'h10,  8'h01, 1'b1, 8'h0E, 1'b0, 1'b0};

        rst_n = 1'b0;
        iv8 = 0; a8 = 0; b8 = 0; bi8 = 0; or8 = 0;
        iv4 = 0; a4 = 0; b4 = 0; bi4 = 0; or4 = 0;
        iv1 = 0; a1 = 0; b1 = 0; bi1 = 0; or1 = 0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(ir8), 32'd1);
        check("rst_out_valid", 32'(ov8), 32'd0);
        check("rst_diff", 32'(d8), 32'd0);
        check("rst_borrow", 32'(bo8), 32'd0);
        check("rst_zero", 32'(z8), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Asynchronous reset in the middle of RUN: F0 - 01 = EF, so after
        // three shifts diff holds 111 in its top bits.
        iv8 = 1'b1; a8 = 8'hF0; b8 = 8'h01; bi8 = 1'b0;
        @(negedge clk);
        iv8 = 1'b0;
        repeat (3) @(negedge clk);
        check("midrun_diff", 32'(d8), 32'hE0);
        check("midrun_in_ready", 32'(ir8), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_in_ready", 32'(ir8), 32'd1);
        check("async_rst_out_valid", 32'(ov8), 32'd0);
        check("async_rst_diff", 32'(d8), 32'd0);
        $display("async reset mid-run: in_ready=%0d out_valid=%0d diff=%02h", ir8, ov8, d8);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op8(8'd5, 8'd3, 1'b0, 8'h02, 1'b0, 1'b0, "post_reset");

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp_diff,
                vecs[i].exp_borrow, vecs[i].exp_zero, $sformatf("vec%0d", i));
        end

        // Handshake: in_valid and out_ready pulsed during RUN are ignored,
        // DONE stalls while out_ready=0, and the next op goes IDLE->accept.
        iv8 = 1'b1; a8 = 8'd100; b8 = 8'd58; bi8 = 1'b0;
        @(negedge clk);
        iv8 = 1'b1; a8 = 8'd7; b8 = 8'd1; or8 = 1'b1;
        @(negedge clk);
        check("hs_run_in_ready", 32'(ir8), 32'd0);
        check("hs_run_out_valid", 32'(ov8), 32'd0);
        @(negedge clk);
        iv8 = 1'b0; or8 = 1'b0;
        lat = 2;
        while (ov8 !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
        check("hs_latency", 32'(lat), 32'd8);
        iv8 = 1'b1; a8 = 8'd9; b8 = 8'd4; bi8 = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check("stall_out_valid", 32'(ov8), 32'd1);
            check("stall_in_ready", 32'(ir8), 32'd0);
            check("stall_diff", 32'(d8), 32'd42);
            check("stall_borrow", 32'(bo8), 32'd0);
            check("stall_zero", 32'(z8), 32'd0);
        end
        $display("stall: diff=%0d held for 5 cycles with out_ready=0", d8);
        or8 = 1'b1;
        @(negedge clk);
        or8 = 1'b0;
        check("hs_idle_in_ready", 32'(ir8), 32'd1);
        check("hs_idle_out_valid", 32'(ov8), 32'd0);
        @(negedge clk);
        iv8 = 1'b0;
        check("hs_next_accepted", 32'(ir8), 32'd0);
        lat = 0;
        while (ov8 !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
        check("hs_next_latency", 32'(lat), 32'd8);
        check("hs_next_diff", 32'(d8), 32'd5);
        $display("back-to-back op: 9 - 4 -> diff=%0d borrow=%0d", d8, bo8);
        or8 = 1'b1;
        @(negedge clk);
        or8 = 1'b0;

        // Exhaustive WIDTH=4 sweep against a - b - borrow_in
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int c = 0; c < 2; c++) begin
                    op4(4'(x), 4'(y), 1'(c));
                end
            end
        end
        $display("w4 sweep: 512 operations, failures so far=%0d", failures);

        // Exhaustive WIDTH=1 sweep: RUN lasts a single edge
        for (int x = 0; x < 2; x++) begin
            for (int y = 0; y < 2; y++) begin
                for (int c = 0; c < 2; c++) begin
                    op1(1'(x), 1'(y), 1'(c));
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
